rx_phase_sync: RTL and testbench
================================

# rx_phase_sync

Receiver-side symbol timing block for the 4x oversampled baseband path. It takes the oversampled stream produced under the transmitter's 4-phase sample counter and measures the energy at each of the four sample phases over a fixed window of symbols. It then selects the phase with the highest energy and decimates the stream to one sample per symbol at that phase. It sits between the receive filter and the slicer/BER checker.

## Interface
- NB_DATA, 8, width of signed input/output samples (two's complement)
- LOG2_WIN, 10, log2 of the number of symbols per energy window (window = 2^LOG2_WIN symbols = 4·2^LOG2_WIN samples)
- NB_ACC, NB_DATA+LOG2_WIN, accumulator width (derived; not overridden)

- clk  input  1  system clock; all logic on rising edge
- i_reset  input  1  synchronous, active-low reset
- i_valid  input  1  sample strobe; one oversampled sample per asserted cycle; may be asserted every cycle or with gaps
- i_data  input  NB_DATA  signed oversampled sample, qualified by i_valid
- o_data  output  NB_DATA  decimated sample at the selected phase
- o_valid  output  1  one-cycle strobe qualifying o_data
- o_phase  output  2  currently selected sample phase (0..3)
- o_lock  output  1  high once the first window decision has been applied

## Operation
- Sample counter: 2-bit counter `ph`, reset 0, increments modulo 4 on each i_valid. It holds when i_valid=0.
- Symbol counter: LOG2_WIN bits, reset 0. It increments when i_valid=1 and ph=3, and wraps to 0 after 2^LOG2_WIN-1.
- Magnitude metric: |i_data|, computed unsigned in NB_DATA bits. The most negative input (e.g. -128) maps to 2^(NB_DATA-1) (128) without overflow.
- Four accumulators acc[0..3], each NB_ACC bits unsigned, reset 0. On i_valid, acc[ph] += |i_data|. The worst case 2^(NB_DATA-1)·2^LOG2_WIN fits, so no saturation is needed.
- Window end: the cycle with i_valid=1, ph=3 and symbol counter = max.
  - Snapshot registers receive acc[0..2] and acc[3]+|i_data|.
  - All accumulators clear to 0.
  - Accumulation of the next window starts with the next valid sample, so no samples are lost.
- FSM states: ACQUIRE, DECIDE, TRACK.
  - ACQUIRE (after reset): o_lock=0, o_phase=0. Decimation runs at phase 0.
  - ACQUIRE → DECIDE at the window-end cycle.
  - DECIDE (exactly one cycle): argmax over the snapshots. A tie resolves to the lowest phase index. The result registers into o_phase; o_lock is set.
  - DECIDE → TRACK unconditionally.
  - TRACK → DECIDE at every subsequent window end. o_lock stays 1 until reset.
- Decimation: when i_valid=1 and ph=o_phase, o_data is loaded with i_data and o_valid=1 on the next cycle. Otherwise o_valid=0 and o_data holds its value.
- Phase change mid-stream: a new o_phase applies from the first sample after the update. The phase change can produce one symbol period with 0 or 2 output strobes; downstream tolerates this.
- Reset mid-operation: all counters, accumulators, snapshots and outputs return to reset values on the next edge. The FSM returns to ACQUIRE.

## Timing
- Reset values: o_data=0, o_valid=0, o_phase=0, o_lock=0.
- Data latency: 1 cycle from the selected-phase sample (i_valid edge) to o_data/o_valid.
- Decision latency:
  - Edge E = the edge at which the window-end sample is captured.
  - Edge E: snapshot captured, FSM enters DECIDE.
  - Edge E+1: o_phase and o_lock updated.
  - The first decimation at the new phase uses samples arriving at or after edge E+2.
- A window end can never coincide with a DECIDE cycle, because a window is at least 4 samples long.
- i_valid gaps freeze ph, the symbol counter and the accumulators. The FSM still advances DECIDE→TRACK regardless of i_valid.

## Test plan
- Impulse at phase 2 (LOG2_WIN=2): feed 0,0,50,0 repeated with i_valid every cycle. Required after 16 samples: o_phase=2 and o_lock=1 at E+1. Every o_valid thereafter carries o_data=50.
- Tie/zero input: all-zero stream for 3 windows. Required: o_phase stays 0, o_lock=1 after the first window, o_data=0 on each strobe.
- Extreme magnitude: phase 1 samples = -128, phase 3 samples = 127, others 0. Required: o_phase=1 (128 > 127), no accumulator overflow at LOG2_WIN=10.
- Gapped valid: the impulse-at-phase-2 pattern with i_valid toggling 1,0,1,0. Required: same decision after 16 valid samples; o_valid appears exactly 1 cycle after each phase-2 valid.
- Phase migration: 2 windows with energy at phase 3, then switch to phase 0. Required: o_phase 3→0 after the third window end, with no accumulator carry-over.
- Reset mid-window: assert i_reset low for 1 cycle midway through window 2. Required: all outputs return to 0 and o_lock=0. The next decision comes only after a full fresh window.

Source files
------------

// File: rtl/rx_phase_sync.sv
// ---------------------------------------------------------------------------
// rx_phase_sync
//
// Receiver-side symbol timing recovery for the 4x oversampled baseband path.
// Sits between the receive filter and the slicer. The incoming stream carries
// four samples per symbol. Over a window of 2^LOG2_WIN symbols, the block adds
// up the magnitude seen at each of the four sample phases. At the end of each
// window it picks the phase with the most energy. It then decimates the stream
// to one sample per symbol at that phase.
//
// Parameters
//   NB_DATA   width of the two's complement input/output samples
//   LOG2_WIN  log2 of the number of symbols in one energy window
//
// Ports
//   clk      system clock, everything on the rising edge
//   i_reset  synchronous, active-low reset
//   i_valid  sample strobe, one oversampled sample per asserted cycle
//   i_data   oversampled sample (two's complement), qualified by i_valid
//   o_data   decimated sample taken at the selected phase
//   o_valid  one-cycle strobe qualifying o_data
//   o_phase  currently selected sample phase (0..3)
//   o_lock   high once the first window decision has been applied
// ---------------------------------------------------------------------------
module rx_phase_sync #(
  parameter int NB_DATA  = 8,
  parameter int LOG2_WIN = 10
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic [1:0]         o_phase,
  output logic               o_lock
);

  // The accumulator width covers a full window of worst-case magnitudes,
  // 2^(NB_DATA-1) * 2^LOG2_WIN, so the accumulators never need saturation.
  localparam int NB_ACC = NB_DATA + LOG2_WIN;

  typedef enum logic [1:0] {
    ACQUIRE,
    DECIDE,
    TRACK
  } PhaseState;

  PhaseState           r_state;
  logic [1:0]          r_ph;
  logic [LOG2_WIN-1:0] r_symCnt;
  logic [NB_ACC-1:0]   r_acc  [4];
  logic [NB_ACC-1:0]   r_snap [4];

  logic [NB_DATA-1:0]  w_mag;
  logic [NB_ACC-1:0]   w_magExt;
  logic                w_windowEnd;
  logic [1:0]          w_bestPhase;
  logic [NB_ACC-1:0]   w_bestVal;

  // Magnitude of the incoming sample, read as unsigned. Negating the most
  // negative code wraps back to the same bit pattern. Read as unsigned, that
  // pattern is exactly 2^(NB_DATA-1), so no extra bit is needed.
  assign w_mag    = i_data[NB_DATA-1] ? (~i_data + {{(NB_DATA-1){1'b0}}, 1'b1}) : i_data;
  assign w_magExt = {{LOG2_WIN{1'b0}}, w_mag};

  // A window closes on the valid sample that lands on phase 3 of the last
  // symbol of the window.
  assign w_windowEnd = i_valid && (r_ph == 2'd3) && (r_symCnt == {LOG2_WIN{1'b1}});

  // Sample phase and symbol counters. Both move only on valid samples, so
  // gaps in i_valid simply freeze the timing reference. The symbol counter
  // wraps naturally at the end of the window.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_ph     <= 2'd0;
      r_symCnt <= '0;
    end else if (i_valid) begin
      r_ph <= r_ph + 2'd1;
      if (r_ph == 2'd3) begin
        r_symCnt <= r_symCnt + LOG2_WIN'(1);
      end
    end
  end

  // Per-phase energy accumulators. On the window-end sample the accumulators
  // clear instead of adding. The final phase-3 contribution goes straight
  // into the snapshot below, so the next window starts clean on the very next
  // valid sample and no sample is dropped.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      for (int p = 0; p < 4; p++) begin
        r_acc[p] <= '0;
      end
    end else if (i_valid) begin
      if (w_windowEnd) begin
        for (int p = 0; p < 4; p++) begin
          r_acc[p] <= '0;
        end
      end else begin
        r_acc[r_ph] <= r_acc[r_ph] + w_magExt;
      end
    end
  end

  // Snapshot of the finished window's energies. The DECIDE cycle then looks at
  // stable values while the live accumulators already collect the next window.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      for (int p = 0; p < 4; p++) begin
        r_snap[p] <= '0;
      end
    end else if (w_windowEnd) begin
      r_snap[0] <= r_acc[0];
      r_snap[1] <= r_acc[1];
      r_snap[2] <= r_acc[2];
      r_snap[3] <= r_acc[3] + w_magExt;
    end
  end

  // Argmax over the snapshot. The scan goes upward and replaces the best
  // entry only on a strict improvement, so a tie keeps the lowest phase index.
  always_comb begin
    w_bestPhase = 2'd0;
    w_bestVal   = r_snap[0];
    for (int p = 1; p < 4; p++) begin
      if (r_snap[p] > w_bestVal) begin
        w_bestVal   = r_snap[p];
        w_bestPhase = 2'(p);
      end
    end
  end

  // Decision FSM with registered phase/lock outputs.
  // ACQUIRE runs decimation at phase 0 until the first window closes.
  // DECIDE lasts exactly one cycle and commits the argmax.
  // TRACK re-decides at every later window end. A window is at least four
  // samples long, so a window end can never land on the DECIDE cycle itself.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_state <= ACQUIRE;
      o_phase <= 2'd0;
      o_lock  <= 1'b0;
    end else begin
      case (r_state)
        ACQUIRE: begin
          if (w_windowEnd) begin
            r_state <= DECIDE;
          end
        end
        DECIDE: begin
          o_phase <= w_bestPhase;
          o_lock  <= 1'b1;
          r_state <= TRACK;
        end
        TRACK: begin
          if (w_windowEnd) begin
            r_state <= DECIDE;
          end
        end
        default: begin
          r_state <= ACQUIRE;
        end
      endcase
    end
  end

  // Decimator: pass through the sample whose phase matches the selected one,
  // one cycle later. A phase update takes effect on the first sample after
  // o_phase changes. Around a change, a symbol period may therefore carry
  // zero or two strobes.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_valid && (r_ph == o_phase)) begin
      o_data  <= i_data;
      o_valid <= 1'b1;
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_phase_sync.sv
// ---------------------------------------------------------------------------
// tb_rx_phase_sync
//
// Drives two copies of rx_phase_sync from the same sample stream.
// One copy uses a short window (LOG2_WIN=2, 16 samples per window).
// The other uses the full-size window (LOG2_WIN=10, 4096 samples per window).
// A behavioural reference kept here counts valid samples since reset and
// sums magnitudes per phase with plain integers. It applies each decision
// one edge after the window closes and predicts o_data/o_valid/o_phase/o_lock
// for both copies on every cycle.
// ---------------------------------------------------------------------------
module tb_rx_phase_sync;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic [7:0] i_data;

  logic [7:0] oDataS, oDataL;
  logic       oValidS, oValidL;
  logic [1:0] oPhaseS, oPhaseL;
  logic       oLockS, oLockL;

  int assertCount = 0;
  int failCount   = 0;

  // Reference state, index 0 = short window copy, index 1 = long window copy
  int         winSamples [2] = '{16, 4096};
  int         mN     [2];
  int         mE     [2][4];
  int         mPhase [2];
  int         mLock  [2];
  int         mPend  [2];
  logic       mValid [2];
  logic [7:0] mData  [2];

  always #5 clk = ~clk;

  rx_phase_sync #(.NB_DATA(8), .LOG2_WIN(2)) dutS (
    .clk     (clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_data  (oDataS),
    .o_valid (oValidS),
    .o_phase (oPhaseS),
    .o_lock  (oLockS)
  );

  rx_phase_sync #(.NB_DATA(8), .LOG2_WIN(10)) dutL (
    .clk     (clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_data  (oDataL),
    .o_valid (oValidL),
    .o_phase (oPhaseL),
    .o_lock  (oLockL)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock edge with the given inputs.
  // The sample's phase is its position since reset modulo 4. A window closes
  // every winSamples valid samples. The winning phase becomes visible one
  // edge later.
  task automatic modelStep(input logic rstn, input logic v, input logic [7:0] d);
    int sd, mag, sel, best;
    sd  = $signed(d);
    mag = (sd < 0) ? -sd : sd;
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        mN[k] = 0; mPhase[k] = 0; mLock[k] = 0; mPend[k] = -1;
        mValid[k] = 1'b0; mData[k] = 8'd0;
        for (int p = 0; p < 4; p++) mE[k][p] = 0;
      end else begin
        sel = mN[k] % 4;
        if (v && sel == mPhase[k]) begin
          mValid[k] = 1'b1;
          mData[k]  = d;
        end else begin
          mValid[k] = 1'b0;
        end
        if (mPend[k] >= 0) begin
          mPhase[k] = mPend[k];
          mLock[k]  = 1;
          mPend[k]  = -1;
        end
        if (v) begin
          mE[k][sel] += mag;
          mN[k]++;
          if (mN[k] % winSamples[k] == 0) begin
            best = 0;
            for (int p = 1; p < 4; p++) if (mE[k][p] > mE[k][best]) best = p;
            mPend[k] = best;
            for (int p = 0; p < 4; p++) mE[k][p] = 0;
          end
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, take the edge, then compare all outputs of
  // both copies against the reference a moment after the edge.
  task automatic applyStimulus(input logic rstn, input logic v, input logic [7:0] d);
    i_reset = rstn;
    i_valid = v;
    i_data  = d;
    @(posedge clk);
    modelStep(rstn, v, d);
    #1;
    checkOutput("S.o_valid", 32'(oValidS), 32'(mValid[0]));
    checkOutput("S.o_data",  32'(oDataS),  32'(mData[0]));
    checkOutput("S.o_phase", 32'(oPhaseS), 32'(mPhase[0]));
    checkOutput("S.o_lock",  32'(oLockS),  32'(mLock[0]));
    checkOutput("L.o_valid", 32'(oValidL), 32'(mValid[1]));
    checkOutput("L.o_data",  32'(oDataL),  32'(mData[1]));
    checkOutput("L.o_phase", 32'(oPhaseL), 32'(mPhase[1]));
    checkOutput("L.o_lock",  32'(oLockL),  32'(mLock[1]));
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'($urandom), 8'($urandom));
  endtask

  // Feed n valid samples whose value depends on the phase position p0..p3.
  // In gapped mode every valid sample is followed by an idle cycle carrying
  // random data that must be ignored.
  task automatic feedSamples(input int n, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3, input bit gapped);
    logic [7:0] val;
    for (int i = 0; i < n; i++) begin
      case (i % 4)
        0: val = p0;
        1: val = p1;
        2: val = p2;
        default: val = p3;
      endcase
      applyStimulus(1'b1, 1'b1, val);
      if (gapped) applyStimulus(1'b1, 1'b0, 8'($urandom));
    end
  endtask

  initial begin
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'd0;

    // Reset values
    doReset(2);
    checkOutput("rst.o_data",  32'(oDataS),  32'd0);
    checkOutput("rst.o_valid", 32'(oValidS), 32'd0);
    checkOutput("rst.o_phase", 32'(oPhaseS), 32'd0);
    checkOutput("rst.o_lock",  32'(oLockS),  32'd0);

    // Impulse at phase 2
    $display("[TB] impulse at phase 2");
    feedSamples(40, 8'd0, 8'd0, 8'd50, 8'd0, 1'b0);
    checkOutput("imp.phase", 32'(oPhaseS), 32'd2);
    checkOutput("imp.lock",  32'(oLockS),  32'd1);
    checkOutput("imp.data",  32'(oDataS),  32'd50);
    checkOutput("imp.Llock", 32'(oLockL),  32'd0);

    // All-zero stream: ties resolve to phase 0
    $display("[TB] all-zero tie");
    doReset(1);
    feedSamples(50, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("tie.phase", 32'(oPhaseS), 32'd0);
    checkOutput("tie.lock",  32'(oLockS),  32'd1);
    checkOutput("tie.data",  32'(oDataS),  32'd0);

    // Extreme magnitude: -128 at phase 1 beats 127 at phase 3
    $display("[TB] extreme magnitude");
    doReset(1);
    feedSamples(4100, 8'd0, 8'h80, 8'd0, 8'd127, 1'b0);
    checkOutput("ext.Lphase", 32'(oPhaseL), 32'd1);
    checkOutput("ext.Llock",  32'(oLockL),  32'd1);
    checkOutput("ext.Ldata",  32'(oDataL),  32'h80);
    checkOutput("ext.Sphase", 32'(oPhaseS), 32'd1);

    // Gapped valid
    $display("[TB] gapped impulse");
    doReset(1);
    feedSamples(40, 8'd0, 8'd0, 8'd50, 8'd0, 1'b1);
    checkOutput("gap.phase", 32'(oPhaseS), 32'd2);
    checkOutput("gap.lock",  32'(oLockS),  32'd1);

    // Phase migration 3 -> 0
    $display("[TB] phase migration");
    doReset(1);
    feedSamples(32, 8'd0, 8'd0, 8'd0, 8'd100, 1'b0);
    feedSamples(4, 8'd100, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("mig.phase3", 32'(oPhaseS), 32'd3);
    feedSamples(16, 8'd100, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("mig.phase0", 32'(oPhaseS), 32'd0);

    // Reset in the middle of the second window
    $display("[TB] reset mid-window");
    doReset(1);
    feedSamples(24, 8'd0, 8'd0, 8'd50, 8'd0, 1'b0);
    checkOutput("mid.before", 32'(oPhaseS), 32'd2);
    applyStimulus(1'b0, 1'b1, 8'd50);
    checkOutput("mid.data",  32'(oDataS),  32'd0);
    checkOutput("mid.valid", 32'(oValidS), 32'd0);
    checkOutput("mid.phase", 32'(oPhaseS), 32'd0);
    checkOutput("mid.lock",  32'(oLockS),  32'd0);
    feedSamples(16, 8'd0, 8'd60, 8'd0, 8'd0, 1'b0);
    checkOutput("mid.nolock", 32'(oLockS), 32'd0);
    feedSamples(1, 8'd0, 8'd60, 8'd0, 8'd0, 1'b0);
    checkOutput("mid.lock1",  32'(oLockS),  32'd1);
    checkOutput("mid.phase1", 32'(oPhaseS), 32'd1);

    // Random traffic with random gaps and an occasional reset
    $display("[TB] random traffic");
    doReset(1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) applyStimulus(1'b0, 1'b1, 8'($urandom));
      else applyStimulus(1'b1, $urandom_range(0, 3) != 0, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
